// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-port integer register file with write bypass and clear sweep
//
// Purpose:
//   Register file for decode/writeback. Two write ports (wr0 = ALU writeback,
//   wr1 = load writeback, wr1 wins on a same-address collision) and NRD
//   synchronous read ports with same-cycle write bypass. After reset, or on
//   clr_in, a sweep zeroes one register per cycle, so the array itself carries
//   no reset.
//
// Ports:
//   clk_in       clock, rising edge
//   rst_n_in     asynchronous active-low reset
//   clr_in       synchronous request to clear all registers
//   ready_o      1 while in RUN (reads/writes serviced)
//   wr0_*_in     write port 0 enable/address/data
//   wr1_*_in     write port 1 enable/address/data (priority over port 0)
//   rd_addr_in   packed read addresses, port p at [p*AW +: AW]
//   rd_data_o    packed registered read data, port p at [p*XLEN +: XLEN]

module reg_file_mp #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 clr_in,
  output logic                 ready_o,
  input  logic                 wr0_en_in,
  input  logic [AW-1:0]        wr0_addr_in,
  input  logic [XLEN-1:0]      wr0_data_in,
  input  logic                 wr1_en_in,
  input  logic [AW-1:0]        wr1_addr_in,
  input  logic [XLEN-1:0]      wr1_data_in,
  input  logic [NRD*AW-1:0]    rd_addr_in,
  output logic [NRD*XLEN-1:0]  rd_data_o
);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        ptr_q;
  logic [XLEN-1:0]      mem [NREG];
  logic [NRD*XLEN-1:0]  rd_data_d;
  logic                 ptr_last;
  logic                 run_ok;
  logic                 wr0_eff, wr1_eff;

  // Address is backed by real storage: in range and not the hardwired zero register.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return ({1'b0, a} < (AW+1)'(NREG)) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign ptr_last = (ptr_q == AW'(NREG - 1));
  assign run_ok   = (state_q == ST_RUN) && !clr_in;
  assign wr0_eff  = run_ok && wr0_en_in && addr_ok(wr0_addr_in);
  assign wr1_eff  = run_ok && wr1_en_in && addr_ok(wr1_addr_in);
  assign ready_o  = (state_q == ST_RUN);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_q <= ST_CLEAR;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR: if (!clr_in && ptr_last) state_d = ST_RUN;
      ST_RUN:   if (clr_in)              state_d = ST_CLEAR;
      default:                           state_d = ST_CLEAR;
    endcase
  end

  // Sweep pointer; explicit wrap on the last entry so non-power-of-two NREG works.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)                ptr_q <= '0;
    else if (clr_in)              ptr_q <= '0;
    else if (state_q == ST_CLEAR) ptr_q <= ptr_last ? '0 : ptr_q + AW'(1);
  end

  // Storage: no reset, the sweep takes care of initial contents.
  // wr1 is written last so it wins a same-address collision.
  always_ff @(posedge clk_in) begin
    if (state_q == ST_CLEAR) begin
      mem[ptr_q] <= '0;
    end else begin
      if (wr0_eff) mem[wr0_addr_in] <= wr0_data_in;
      if (wr1_eff) mem[wr1_addr_in] <= wr1_data_in;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]   a;
    logic [XLEN-1:0] v;

    assign a = rd_addr_in[p*AW +: AW];

    always_comb begin
      v = '0;
      if (run_ok && addr_ok(a)) begin
        if (wr1_eff && (wr1_addr_in == a))      v = wr1_data_in;
        else if (wr0_eff && (wr0_addr_in == a)) v = wr0_data_in;
        else                                    v = mem[a];
      end
    end

    assign rd_data_d[p*XLEN +: XLEN] = v;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) rd_data_o <= '0;
    else           rd_data_o <= rd_data_d;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - scoreboard bench for reg_file_mp (ZERO_REG=1 and ZERO_REG=0 builds)

module tb_reg_file_mp;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        clr_in = 1'b0;
  logic        wr0_en = 1'b0, wr1_en = 1'b0;
  logic [4:0]  wr0_addr = '0, wr1_addr = '0;
  logic [31:0] wr0_data = '0, wr1_data = '0;
  logic [4:0]  ra0 = '0, ra1 = '0;
  logic        ready_z1, ready_z0;
  logic [63:0] rd_z1, rd_z0;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [63:0] e_z1;
    logic [63:0] e_z0;
    int          id;
  } exp_t;

  exp_t sb[$];
  logic chk = 1'b0;
  logic chk_d = 1'b0;
  int   rd_id = 0;

  always #5 clk_in = ~clk_in;

  reg_file_mp #(.XLEN(32), .NREG(32), .NRD(2), .ZERO_REG(1)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .clr_in(clr_in), .ready_o(ready_z1),
    .wr0_en_in(wr0_en), .wr0_addr_in(wr0_addr), .wr0_data_in(wr0_data),
    .wr1_en_in(wr1_en), .wr1_addr_in(wr1_addr), .wr1_data_in(wr1_data),
    .rd_addr_in({ra1, ra0}), .rd_data_o(rd_z1)
  );

  reg_file_mp #(.XLEN(32), .NREG(32), .NRD(2), .ZERO_REG(0)) dut_z (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .clr_in(clr_in), .ready_o(ready_z0),
    .wr0_en_in(wr0_en), .wr0_addr_in(wr0_addr), .wr0_data_in(wr0_data),
    .wr1_en_in(wr1_en), .wr1_addr_in(wr1_addr), .wr1_data_in(wr1_data),
    .rd_addr_in({ra1, ra0}), .rd_data_o(rd_z0)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Read result appears one edge after issue; check it on the following falling edge.
  always @(posedge clk_in) chk_d <= chk;

  always @(negedge clk_in) begin
    if (chk_d) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check($sformatf("rd%0d_zero1", e.id), rd_z1, e.e_z1);
        check($sformatf("rd%0d_zero0", e.id), rd_z0, e.e_z0);
      end
    end
  end

  // Apply current inputs for one cycle; optionally expect a read result.
  task automatic cyc(input logic do_chk, input logic [63:0] e_z1, input logic [63:0] e_z0);
    if (do_chk) begin
      sb.push_back('{e_z1, e_z0, rd_id});
      rd_id++;
    end
    chk = do_chk;
    @(posedge clk_in); #1;
    chk = 1'b0; wr0_en = 1'b0; wr1_en = 1'b0; clr_in = 1'b0;
  endtask

  task automatic edges(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in); #1;
    end
  endtask

  // Count edges until ready_o rises (bounded).
  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (n < 100) begin
      @(posedge clk_in); #1;
      n++;
      if (ready_z1 && ready_z0) break;
    end
    check(name, 64'(n), 64'd32);
  endtask

  task automatic read_all_zero();
    for (int i = 0; i < 32; i++) begin
      ra0 = 5'(i); ra1 = 5'(31 - i);
      cyc(1'b1, 64'd0, 64'd0);
    end
  endtask

  task automatic fill_all();
    for (int i = 0; i < 32; i++) begin
      wr0_en = 1'b1; wr0_addr = 5'(i); wr0_data = 32'h100 + 32'(i);
      cyc(1'b0, '0, '0);
    end
  endtask

  initial begin
    edges(3);
    check("reset_ready", {62'd0, ready_z1, ready_z0}, 64'd0);
    check("reset_rd_z1", rd_z1, 64'd0);
    check("reset_rd_z0", rd_z0, 64'd0);
    rst_n_in = 1'b1;
    check("release_ready", {62'd0, ready_z1, ready_z0}, 64'd0);

    // 1: sweep length and cleared contents
    wait_ready("sweep_after_reset");
    read_all_zero();

    // 2: plain write then read
    wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hDEADBEEF;
    cyc(1'b0, '0, '0);
    ra0 = 5'd5; ra1 = 5'd0;
    cyc(1'b1, 64'h00000000_DEADBEEF, 64'h00000000_DEADBEEF);

    // 3: same-cycle bypass on port 1
    wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'h12345678;
    ra0 = 5'd5; ra1 = 5'd7;
    cyc(1'b1, 64'h12345678_DEADBEEF, 64'h12345678_DEADBEEF);

    // 4: both ports to x9, wr1 wins in bypass and storage
    wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 32'h1111;
    wr1_en = 1'b1; wr1_addr = 5'd9; wr1_data = 32'h2222;
    ra0 = 5'd9; ra1 = 5'd9;
    cyc(1'b1, 64'h00002222_00002222, 64'h00002222_00002222);
    ra0 = 5'd9; ra1 = 5'd7;
    cyc(1'b1, 64'h12345678_00002222, 64'h12345678_00002222);

    // distinct-address dual write, both bypassed
    wr0_en = 1'b1; wr0_addr = 5'd4; wr0_data = 32'hA0A0A0A0;
    wr1_en = 1'b1; wr1_addr = 5'd3; wr1_data = 32'h0B0B0B0B;
    ra0 = 5'd4; ra1 = 5'd3;
    cyc(1'b1, 64'h0B0B0B0B_A0A0A0A0, 64'h0B0B0B0B_A0A0A0A0);

    // 5: write to x0
    wr1_en = 1'b1; wr1_addr = 5'd0; wr1_data = 32'hFFFFFFFF;
    ra0 = 5'd0; ra1 = 5'd0;
    cyc(1'b1, 64'd0, 64'hFFFFFFFF_FFFFFFFF);
    ra0 = 5'd0; ra1 = 5'd5;
    cyc(1'b1, 64'hDEADBEEF_00000000, 64'hDEADBEEF_FFFFFFFF);

    // 6: fill, clear (write in clr cycle dropped), verify sweep
    fill_all();
    ra0 = 5'd31; ra1 = 5'd1;
    cyc(1'b1, 64'h00000101_0000011F, 64'h00000101_0000011F);
    ra0 = 5'd0; ra1 = 5'd16;
    cyc(1'b1, 64'h00000110_00000000, 64'h00000110_00000100);
    clr_in = 1'b1;
    wr0_en = 1'b1; wr0_addr = 5'd10; wr0_data = 32'hAAAA;
    ra0 = 5'd10; ra1 = 5'd2;
    cyc(1'b1, 64'd0, 64'd0);
    check("clr_ready_low", {62'd0, ready_z1, ready_z0}, 64'd0);
    wait_ready("sweep_after_clr");
    read_all_zero();

    // clr during sweep restarts the pointer
    fill_all();
    clr_in = 1'b1;
    cyc(1'b0, '0, '0);
    edges(5);
    clr_in = 1'b1;
    cyc(1'b0, '0, '0);
    wait_ready("sweep_after_clr_in_clear");

    // reset at sweep cycle 10 restarts the full sweep
    fill_all();
    clr_in = 1'b1;
    cyc(1'b0, '0, '0);
    edges(10);
    rst_n_in = 1'b0;
    #1;
    check("midreset_ready", {62'd0, ready_z1, ready_z0}, 64'd0);
    check("midreset_rd", rd_z1 | rd_z0, 64'd0);
    edges(2);
    rst_n_in = 1'b1;
    wait_ready("sweep_after_midreset");
    read_all_zero();

    edges(2);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
